// File: rtl/ntt_pkg.sv
// Shared parameters, types and modular-reduction helper for the 8-point NTT controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ntt_pkg;

    localparam int N    = 8;
    localparam int DW   = 8;
    localparam int MOD  = 17;
    localparam int ROOT = 9;
    localparam int LW   = $clog2(N);

    typedef logic [DW-1:0]   coef_t;
    typedef logic [2*DW-1:0] wide_t;
    typedef logic [LW-1:0]   idx_t;

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

    localparam wide_t MOD_W  = wide_t'(MOD);
    localparam coef_t ROOT_C = coef_t'(ROOT);
    localparam idx_t  LAST   = idx_t'(N - 1);

    // Reduce a double-width value into [0, MOD); the result always fits in DW bits.
    function automatic coef_t mod_red(input wide_t v);
        return coef_t'(v % MOD_W);
    endfunction

endpackage

// File: rtl/ntt_seq_ctrl_if.sv
// Input and output coefficient streams plus the busy flag of the NTT controller.
// Latency: n/a (wiring only).
// Backpressure: in_ready gates the input stream, out_ready stalls the output stream.
interface ntt_seq_ctrl_if;
    import ntt_pkg::*;

    coef_t in_data;
    logic  in_valid;
    logic  in_ready;
    coef_t out_data;
    logic  out_valid;
    logic  out_last;
    logic  out_ready;
    logic  busy;

    // Producer/consumer side that talks to the controller.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    // Controller side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );

endinterface

// File: rtl/mod_mul.sv
// Combinational modular multiplier: p = a*b mod MOD.
// Latency: 0 cycles (pure combinational, full 2*DW-bit product reduced in place).
// Backpressure: none.
module mod_mul
    import ntt_pkg::*;
(
    input  coef_t a,
    input  coef_t b,
    output coef_t p
);

    assign p = mod_red(wide_t'(a) * wide_t'(b));

endmodule

// File: rtl/ntt_seq_ctrl.sv
// 8-point NTT sequencer: load N coefficients, run N*N MAC cycles on one shared multiplier, stream N results.
// Latency: last input accepted at edge t -> first out_valid at edge t+N*N+1.
// Backpressure: in_ready only in LOAD; out_ready low freezes out_data/out_valid with no loss or reorder.
module ntt_seq_ctrl
    import ntt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ntt_seq_ctrl_if.slave bus
);

    state_t state;
    state_t state_nxt;

    idx_t  lcnt;
    idx_t  j;
    idx_t  k;
    idx_t  ocnt;
    idx_t  ocnt_inc;
    coef_t x [N];
    coef_t y [N];
    coef_t acc;
    coef_t w;
    coef_t wk;
    coef_t out_data_q;
    logic  out_valid_q;
    logic  out_last_q;
    logic  busy_q;
    logic  in_ready_c;

    coef_t mac_p;
    coef_t tw_a;
    coef_t tw_b;
    coef_t tw_p;
    coef_t acc_nxt;
    logic  in_fire;
    logic  out_fire;
    logic  row_end;

    assign in_fire  = bus.in_valid && (state == LOAD);
    assign out_fire = out_valid_q && bus.out_ready;
    assign row_end  = (j == LAST);
    assign ocnt_inc = ocnt + 1'b1;

    // MAC path: x[j]*w accumulated, reduced before it is registered.
    mod_mul u_mac (
        .a (x[j]),
        .b (w),
        .p (mac_p)
    );
    assign acc_nxt = mod_red(wide_t'(acc) + wide_t'(mac_p));

    // Twiddle path: advances w by wk inside a row; at row end the same
    // multiplier steps the row twiddle wk by ROOT instead.
    assign tw_a = row_end ? wk : w;
    assign tw_b = row_end ? ROOT_C : wk;
    mod_mul u_tw (
        .a (tw_a),
        .b (tw_b),
        .p (tw_p)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next-state decode and input-side ready.
    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        case (state)
            LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && (lcnt == LAST)) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                if (row_end && (k == LAST)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_fire && (ocnt == LAST)) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Datapath: coefficient capture, MAC/twiddle sequencing and result drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt        <= '0;
            j           <= '0;
            k           <= '0;
            ocnt        <= '0;
            acc         <= '0;
            w           <= '0;
            wk          <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                x[i] <= '0;
                y[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        x[lcnt] <= mod_red(wide_t'(bus.in_data));
                        busy_q  <= 1'b1;
                        lcnt    <= lcnt + 1'b1;
                        if (lcnt == LAST) begin
                            k   <= '0;
                            j   <= '0;
                            acc <= '0;
                            wk  <= coef_t'(1);
                            w   <= coef_t'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (row_end) begin
                        y[k] <= acc_nxt;
                        acc  <= '0;
                        j    <= '0;
                        k    <= k + 1'b1;
                        wk   <= tw_p;
                        w    <= coef_t'(1);
                    end else begin
                        acc <= acc_nxt;
                        w   <= tw_p;
                        j   <= j + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!out_valid_q) begin
                        // First cycle in DRAIN presents y[0] from the result buffer.
                        out_valid_q <= 1'b1;
                        out_data_q  <= y[ocnt];
                        out_last_q  <= (ocnt == LAST);
                    end else if (bus.out_ready) begin
                        if (ocnt == LAST) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            ocnt        <= '0;
                            lcnt        <= '0;
                            busy_q      <= 1'b0;
                        end else begin
                            ocnt       <= ocnt_inc;
                            out_data_q <= y[ocnt_inc];
                            out_last_q <= (ocnt_inc == LAST);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
